ram_alu_seq: RTL and testbench
==============================

// Module: ram_alu_seq
// PURPOSE
//  Upstream sequencer for the RAM_ALU stage. Accepts one {op, X, Y} job per valid/ready
//  handshake and drives the RAM_ALU port protocol: write X to addr 0, write Y to addr 1,
//  then read the result from addr 2. Captures the 32-bit DOut and presents it downstream
//  with a valid/ready handshake. Rejects divide/modulo-by-zero jobs without touching the ALU.
// PARAMETERS
//  DW      16  operand width (X, Y, alu_din)
//  RW      32  result width (alu_dout, out_result)
//  RD_LAT  1   clk cycles addr=2/r=1 is held before alu_dout is sampled (>=1)
//  CW      8   width of the completed-job counter
// PORTS
//  clk         in   1    single clock, rising edge
//  rst_n       in   1    asynchronous, active-low reset
//  in_valid    in   1    job offered
//  in_ready    out  1    sequencer can accept a job
//  in_op       in   2    0:(X+Y)*(X-Y)  1:X%Y  2:X/Y  3:X%(X-Y)
//  in_x        in   DW   operand X
//  in_y        in   DW   operand Y
//  out_valid   out  1    result held valid
//  out_ready   in   1    downstream accepts the result
//  out_result  out  RW   captured ALU result (0 when out_err=1)
//  out_err     out  1    job rejected (zero divisor)
//  out_op      out  2    op of the job the result belongs to
//  job_cnt     out  CW   count of completed (handed-off) jobs, error jobs included
//  alu_e       out  1    RAM_ALU enable
//  alu_op      out  2    RAM_ALU op select
//  alu_din     out  DW   RAM_ALU DIn
//  alu_addr    out  2    RAM_ALU addr
//  alu_w       out  1    RAM_ALU write strobe
//  alu_r       out  1    RAM_ALU read strobe
//  alu_dout    in   RW   RAM_ALU DOut
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE; in_ready=0, out_valid=0, out_err=0, out_result=0,
//   out_op=0, job_cnt=0, alu_e=0, alu_w=0, alu_r=0, alu_addr=0, alu_din=0, alu_op=0.
//   All outputs registered. Reset mid-job aborts it; the partial job is never reported.
//  First clk after reset release: in_ready=1, alu_e=1 (alu_e stays 1 until next reset).
//  FSM: IDLE -> WR_X -> WR_Y -> RD -> HOLD -> IDLE; error path IDLE -> HOLD.
//  IDLE: in_ready=1. Accept on in_valid&in_ready; latch op,X,Y; in_ready drops next cycle.
//   Zero check on latched job: op1/op2 with Y==0, or op3 with X==Y -> err job, go HOLD.
//   op0 never errors.
//  WR_X (1 cycle): alu_addr=0, alu_din=X, alu_w=1, alu_r=0, alu_op=op.
//  WR_Y (1 cycle): alu_addr=1, alu_din=Y, alu_w=1, alu_r=0.
//  RD (RD_LAT cycles, down-counter): alu_addr=2, alu_w=0, alu_r=1; on the last RD cycle
//   out_result<=alu_dout, out_err<=0, out_valid<=1.
//  alu_op held constant from WR_X through RD; alu_din holds Y after WR_Y.
//  alu_w/alu_r are never both 1; outside WR_X/WR_Y/RD, alu_w=0, alu_r=0, alu_addr=0.
//  HOLD: out_valid=1; out_result, out_err, out_op stable until out_ready=1.
//   Err path: out_result=0, out_err=1, out_valid=1 one cycle after accept; no alu_w/alu_r.
//   On out_valid&out_ready: out_valid<=0, job_cnt<=job_cnt+1 (wraps 2^CW-1 -> 0), go IDLE,
//   in_ready<=1 next cycle. out_ready is ignored while out_valid=0.
//  Latency (RD_LAT=1): accept at edge N -> WR_X N+1, WR_Y N+2, RD N+3, out_valid N+4.
//   Min issue interval 5 cycles (out_ready held 1). Error job: out_valid at N+1.
//  in_valid while in_ready=0 is ignored (not queued). No arithmetic inside; result is
//   alu_dout verbatim.
// TESTING (bench instantiates a behavioural RAM_ALU with matching RD_LAT)
//  Reset: rst_n=0 -> all outputs 0; release -> in_ready=1 one edge later, alu_e=1.
//  op0 X=445,Y=100 -> alu writes 445@0,100@1, read @2; out_result=188025, out_err=0,
//   out_valid 4 cycles after accept; op0 X=1000,Y=1000 -> 0, out_err=0.
//  op1 445,100 -> 45; op2 445,100 -> 4; op3 445,100 -> 100; op3 1000,250 -> 250.
//  op2 Y=0, op1 Y=0, op3 X=Y=1000 -> out_err=1, out_result=0, out_valid 1 cycle after
//   accept, alu_w/alu_r never asserted.
//  Backpressure: out_ready=0 for 10 cycles -> out_* stable, in_ready=0, in_valid ignored;
//   then out_ready=1 -> job_cnt+1, in_ready=1 next cycle.
//  rst_n pulse during RD -> outputs reset immediately, no out_valid; job_cnt 255+1 -> 0.

Source files
------------

// File: rtl/ram_alu_seq.sv
// Sequencer in front of the RAM_ALU stage. It takes one {op, X, Y} job at a time,
// writes X to addr 0 and Y to addr 1, reads the result from addr 2 and holds it for
// the downstream consumer. A job whose divisor is zero is answered with an error
// at once and never reaches the ALU.
module ram_alu_seq #(
    parameter int DW     = 16,
    parameter int RW     = 32,
    parameter int RD_LAT = 1,
    parameter int CW     = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [1:0]    in_op,
    input  logic [DW-1:0] in_x,
    input  logic [DW-1:0] in_y,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [RW-1:0] out_result,
    output logic          out_err,
    output logic [1:0]    out_op,
    output logic [CW-1:0] job_cnt,
    output logic          alu_e,
    output logic [1:0]    alu_op,
    output logic [DW-1:0] alu_din,
    output logic [1:0]    alu_addr,
    output logic          alu_w,
    output logic          alu_r,
    input  logic [RW-1:0] alu_dout
);

    // Read-phase down-counter width; at least one bit even when RD_LAT is 1.
    localparam int LW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    typedef enum logic [2:0] {
        IDLE,
        WR_X,
        WR_Y,
        RD,
        HOLD
    } state_t;

    state_t        state_reg, state_next;
    logic          in_ready_reg, in_ready_next;
    logic          out_valid_reg, out_valid_next;
    logic [RW-1:0] out_result_reg, out_result_next;
    logic          out_err_reg, out_err_next;
    logic [1:0]    out_op_reg, out_op_next;
    logic [CW-1:0] job_cnt_reg, job_cnt_next;
    logic          alu_e_reg, alu_e_next;
    logic [1:0]    alu_op_reg, alu_op_next;
    logic [DW-1:0] alu_din_reg, alu_din_next;
    logic [1:0]    alu_addr_reg, alu_addr_next;
    logic          alu_w_reg, alu_w_next;
    logic          alu_r_reg, alu_r_next;
    logic [DW-1:0] y_reg, y_next;
    logic [LW-1:0] rd_cnt_reg, rd_cnt_next;
    logic          zero_div;

    // Divisor check on the offered job: op1/op2 divide by Y, op3 divides by X-Y.
    always_comb begin
        zero_div = (((in_op == 2'd1) || (in_op == 2'd2)) && (in_y == '0)) ||
                   ((in_op == 2'd3) && (in_x == in_y));
    end

    // State and registered outputs; reset aborts any job in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            in_ready_reg   <= 1'b0;
            out_valid_reg  <= 1'b0;
            out_result_reg <= '0;
            out_err_reg    <= 1'b0;
            out_op_reg     <= 2'd0;
            job_cnt_reg    <= '0;
            alu_e_reg      <= 1'b0;
            alu_op_reg     <= 2'd0;
            alu_din_reg    <= '0;
            alu_addr_reg   <= 2'd0;
            alu_w_reg      <= 1'b0;
            alu_r_reg      <= 1'b0;
            y_reg          <= '0;
            rd_cnt_reg     <= '0;
        end else begin
            state_reg      <= state_next;
            in_ready_reg   <= in_ready_next;
            out_valid_reg  <= out_valid_next;
            out_result_reg <= out_result_next;
            out_err_reg    <= out_err_next;
            out_op_reg     <= out_op_next;
            job_cnt_reg    <= job_cnt_next;
            alu_e_reg      <= alu_e_next;
            alu_op_reg     <= alu_op_next;
            alu_din_reg    <= alu_din_next;
            alu_addr_reg   <= alu_addr_next;
            alu_w_reg      <= alu_w_next;
            alu_r_reg      <= alu_r_next;
            y_reg          <= y_next;
            rd_cnt_reg     <= rd_cnt_next;
        end
    end

    // Next-state and next-output logic; the ALU strobes are set one cycle ahead
    // so that each registered strobe lines up with its phase.
    always_comb begin
        state_next      = state_reg;
        in_ready_next   = in_ready_reg;
        out_valid_next  = out_valid_reg;
        out_result_next = out_result_reg;
        out_err_next    = out_err_reg;
        out_op_next     = out_op_reg;
        job_cnt_next    = job_cnt_reg;
        alu_e_next      = 1'b1;
        alu_op_next     = alu_op_reg;
        alu_din_next    = alu_din_reg;
        alu_addr_next   = alu_addr_reg;
        alu_w_next      = alu_w_reg;
        alu_r_next      = alu_r_reg;
        y_next          = y_reg;
        rd_cnt_next     = rd_cnt_reg;

        case (state_reg)
            IDLE: begin
                if (in_valid && in_ready_reg) begin
                    in_ready_next = 1'b0;
                    out_op_next   = in_op;
                    if (zero_div) begin
                        state_next      = HOLD;
                        out_valid_next  = 1'b1;
                        out_err_next    = 1'b1;
                        out_result_next = '0;
                    end else begin
                        state_next    = WR_X;
                        y_next        = in_y;
                        alu_op_next   = in_op;
                        alu_addr_next = 2'd0;
                        alu_din_next  = in_x;
                        alu_w_next    = 1'b1;
                    end
                end else begin
                    // Also raises in_ready on the first clock after reset release.
                    in_ready_next = 1'b1;
                end
            end
            WR_X: begin
                state_next    = WR_Y;
                alu_addr_next = 2'd1;
                alu_din_next  = y_reg;
                alu_w_next    = 1'b1;
            end
            WR_Y: begin
                state_next    = RD;
                alu_addr_next = 2'd2;
                alu_w_next    = 1'b0;
                alu_r_next    = 1'b1;
                rd_cnt_next   = LW'(RD_LAT - 1);
            end
            RD: begin
                if (rd_cnt_reg == '0) begin
                    state_next      = HOLD;
                    out_result_next = alu_dout;
                    out_err_next    = 1'b0;
                    out_valid_next  = 1'b1;
                    out_op_next     = alu_op_reg;
                    alu_r_next      = 1'b0;
                    alu_addr_next   = 2'd0;
                end else begin
                    rd_cnt_next = rd_cnt_reg - LW'(1);
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_next     = IDLE;
                    out_valid_next = 1'b0;
                    job_cnt_next   = job_cnt_reg + CW'(1);
                    in_ready_next  = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign in_ready   = in_ready_reg;
    assign out_valid  = out_valid_reg;
    assign out_result = out_result_reg;
    assign out_err    = out_err_reg;
    assign out_op     = out_op_reg;
    assign job_cnt    = job_cnt_reg;
    assign alu_e      = alu_e_reg;
    assign alu_op     = alu_op_reg;
    assign alu_din    = alu_din_reg;
    assign alu_addr   = alu_addr_reg;
    assign alu_w      = alu_w_reg;
    assign alu_r      = alu_r_reg;

endmodule

// File: tb/tb_ram_alu_seq.sv
// Scoreboard bench for ram_alu_seq with a behavioural RAM_ALU attached.
module tb_ram_alu_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic [15:0] in_x;
    logic [15:0] in_y;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_err;
    logic [1:0]  out_op;
    logic [7:0]  job_cnt;
    logic        alu_e;
    logic [1:0]  alu_op;
    logic [15:0] alu_din;
    logic [1:0]  alu_addr;
    logic        alu_w;
    logic        alu_r;
    logic [31:0] alu_dout;

    ram_alu_seq #(.DW(16), .RW(32), .RD_LAT(1), .CW(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_x       (in_x),
        .in_y       (in_y),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_err    (out_err),
        .out_op     (out_op),
        .job_cnt    (job_cnt),
        .alu_e      (alu_e),
        .alu_op     (alu_op),
        .alu_din    (alu_din),
        .alu_addr   (alu_addr),
        .alu_w      (alu_w),
        .alu_r      (alu_r),
        .alu_dout   (alu_dout)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [1:0]  op;
        logic [15:0] x;
        logic [15:0] y;
        logic        err;
        logic [31:0] res;
        int          rise_cyc;
    } exp_t;

    typedef struct {
        logic [1:0]  addr;
        logic [15:0] din;
    } wr_t;

    exp_t       exp_q[$];
    wr_t        wr_q[$];
    logic [7:0] jc_model = 8'd0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // The ALU's arithmetic, stated directly from the op table.
    function automatic logic [31:0] alu_f(input logic [1:0] op, input logic [15:0] x,
                                          input logic [15:0] y);
        logic [31:0] a;
        logic [31:0] b;
        a = {16'd0, x};
        b = {16'd0, y};
        case (op)
            2'd0:    return (a + b) * (a - b);
            2'd1:    return (b == 32'd0) ? 32'd0 : a % b;
            2'd2:    return (b == 32'd0) ? 32'd0 : a / b;
            default: return (a == b) ? 32'd0 : a % (a - b);
        endcase
    endfunction

    // Behavioural RAM_ALU: two operand cells, result readable combinationally at addr 2.
    logic [15:0] mem0 = 16'd0;
    logic [15:0] mem1 = 16'd0;

    always @(posedge clk) begin
        if (alu_e && alu_w) begin
            if (alu_addr == 2'd0) mem0 <= alu_din;
            else if (alu_addr == 2'd1) mem1 <= alu_din;
        end
    end

    always_comb begin
        alu_dout = 32'hDEADBEEF;
        if (alu_e && alu_r && (alu_addr == 2'd2)) alu_dout = alu_f(alu_op, mem0, mem1);
    end

    // Input monitor: every accepted job pushes its expected response and ALU writes.
    always @(negedge clk) begin
        if (rst_n && in_valid && in_ready) begin
            exp_t e;
            wr_t  w;
            e.op  = in_op;
            e.x   = in_x;
            e.y   = in_y;
            e.err = (((in_op == 2'd1) || (in_op == 2'd2)) && (in_y == 16'd0)) ||
                    ((in_op == 2'd3) && (in_x == in_y));
            e.res = e.err ? 32'd0 : alu_f(in_op, in_x, in_y);
            e.rise_cyc = cyc + (e.err ? 1 : 4);
            exp_q.push_back(e);
            if (!e.err) begin
                w.addr = 2'd0; w.din = in_x; wr_q.push_back(w);
                w.addr = 2'd1; w.din = in_y; wr_q.push_back(w);
            end
        end
    end

    // Output monitor: latency, held values, handshake and job counter.
    logic prev_valid = 1'b0;
    logic hs_pend    = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid = 1'b0;
            hs_pend    = 1'b0;
        end else begin
            if (hs_pend) begin
                chk("in_ready_after_handoff", 64'(in_ready), 64'(1));
                chk("out_valid_after_handoff", 64'(out_valid), 64'(0));
                hs_pend = 1'b0;
            end
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_out_valid", 64'(exp_q.size()), 64'(1));
                end else begin
                    if (!prev_valid) chk("latency_cycle", 64'(cyc), 64'(exp_q[0].rise_cyc));
                    chk("out_result", 64'(out_result), 64'(exp_q[0].res));
                    chk("out_err", 64'(out_err), 64'(exp_q[0].err));
                    chk("out_op", 64'(out_op), 64'(exp_q[0].op));
                    chk("in_ready_while_busy", 64'(in_ready), 64'(0));
                    if (out_ready) begin
                        chk("job_cnt", 64'(job_cnt), 64'(jc_model));
                        $display("job op=%0d x=%0d y=%0d result=%0d err=%0d job_cnt=%0d",
                                 exp_q[0].op, exp_q[0].x, exp_q[0].y, out_result, out_err,
                                 job_cnt);
                        void'(exp_q.pop_front());
                        jc_model = jc_model + 8'd1;
                        hs_pend  = 1'b1;
                    end
                end
            end
            prev_valid = out_valid;
        end
    end

    // ALU port monitor: strobe exclusivity, write order/data, idle address.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("w_r_exclusive", 64'(alu_w & alu_r), 64'(0));
            if (alu_w) begin
                if (wr_q.size() == 0) begin
                    chk("write_expected", 64'(wr_q.size()), 64'(1));
                end else begin
                    chk("write_addr", 64'(alu_addr), 64'(wr_q[0].addr));
                    chk("write_data", 64'(alu_din), 64'(wr_q[0].din));
                    void'(wr_q.pop_front());
                end
            end else if (alu_r) begin
                chk("read_addr", 64'(alu_addr), 64'(2));
                chk("read_for_valid_job", 64'((exp_q.size() != 0) && !exp_q[0].err), 64'(1));
            end else begin
                chk("idle_addr", 64'(alu_addr), 64'(0));
            end
        end
    end

    task automatic check_reset_outputs();
        chk("rst_in_ready", 64'(in_ready), 64'(0));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_err", 64'(out_err), 64'(0));
        chk("rst_out_result", 64'(out_result), 64'(0));
        chk("rst_out_op", 64'(out_op), 64'(0));
        chk("rst_job_cnt", 64'(job_cnt), 64'(0));
        chk("rst_alu_e", 64'(alu_e), 64'(0));
        chk("rst_alu_w", 64'(alu_w), 64'(0));
        chk("rst_alu_r", 64'(alu_r), 64'(0));
        chk("rst_alu_addr", 64'(alu_addr), 64'(0));
        chk("rst_alu_din", 64'(alu_din), 64'(0));
        chk("rst_alu_op", 64'(alu_op), 64'(0));
    endtask

    // Called shortly after a rising edge; releases reset mid-cycle.
    task automatic release_reset();
        #2 rst_n = 1'b1;
        #1;
        chk("in_ready_at_release", 64'(in_ready), 64'(0));
        @(posedge clk);
        #1;
        chk("in_ready_first_clk", 64'(in_ready), 64'(1));
        chk("alu_e_first_clk", 64'(alu_e), 64'(1));
    endtask

    // mode 0: out_ready=1, mode 1: random out_ready, mode 2: 10 cycles of backpressure.
    task automatic send(input logic [1:0] op, input logic [15:0] x, input logic [15:0] y,
                        input int mode);
        int t;
        int vcnt;
        t = 0;
        while (!in_ready && t < 50) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("in_ready_before_send", 64'(in_ready), 64'(1));
        in_op    = op;
        in_x     = x;
        in_y     = y;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        t    = 0;
        vcnt = 0;
        while (exp_q.size() != 0 && t < 100) begin
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (($urandom % 4) != 0);
                default: out_ready = (vcnt >= 10);
            endcase
            // Junk offers while busy must be ignored.
            if (!in_ready) begin
                in_valid = 1'($urandom);
                in_op    = 2'($urandom);
                in_x     = 16'($urandom);
                in_y     = 16'($urandom % 2);
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk);
            #1;
            t++;
            if (out_valid) vcnt++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("job_completed", 64'(exp_q.size()), 64'(0));
    endtask

    task automatic reset_during_rd();
        int t;
        in_op    = 2'd0;
        in_x     = 16'd300;
        in_y     = 16'd7;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        t = 0;
        while (!alu_r && t < 20) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("reached_read_phase", 64'(alu_r), 64'(1));
        #1 rst_n = 1'b0;
        #1;
        check_reset_outputs();
        exp_q.delete();
        wr_q.delete();
        jc_model = 8'd0;
        @(posedge clk);
        #1;
        chk("no_valid_in_reset", 64'(out_valid), 64'(0));
        release_reset();
    endtask

    logic [1:0]  d_op[9] = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd2, 2'd1, 2'd3};
    logic [15:0] d_x[9]  = '{16'd445, 16'd1000, 16'd445, 16'd445, 16'd445, 16'd1000,
                             16'd445, 16'd7, 16'd1000};
    logic [15:0] d_y[9]  = '{16'd100, 16'd1000, 16'd100, 16'd100, 16'd100, 16'd250,
                             16'd0, 16'd0, 16'd1000};

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_op     = 2'd0;
        in_x      = 16'd0;
        in_y      = 16'd0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs();
        release_reset();

        for (int i = 0; i < 9; i++) send(d_op[i], d_x[i], d_y[i], 0);

        send(2'd0, 16'd445, 16'd100, 2);
        send(2'd2, 16'd9, 16'd0, 2);

        reset_during_rd();

        // Enough handoffs after the reset to wrap the 8-bit job counter.
        for (int i = 0; i < 262; i++) begin
            logic [1:0]  op;
            logic [15:0] x;
            logic [15:0] y;
            logic [15:0] tmp;
            int          r;
            op = 2'($urandom);
            x  = 16'($urandom);
            r  = int'($urandom % 8);
            if (r == 0) y = 16'd0;
            else if (r == 1) y = x;
            else y = 16'($urandom);
            if (op == 2'd3 && x < y) begin
                tmp = x; x = y; y = tmp;
            end
            send(op, x, y, 1);
        end

        repeat (4) @(posedge clk);
        #1;
        chk("job_cnt_final", 64'(job_cnt), 64'(jc_model));
        chk("exp_queue_drained", 64'(exp_q.size()), 64'(0));
        chk("write_queue_drained", 64'(wr_q.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
